// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sequencer sharing one registered arithmetic unit between two requesters
module alu_req_arbiter #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      req0,
  input  logic [IN_DATA_WIDTH-1:0]  A0,
  input  logic [IN_DATA_WIDTH-1:0]  B0,
  input  logic [1:0]                FUNC0,
  output logic                      gnt0,
  input  logic                      req1,
  input  logic [IN_DATA_WIDTH-1:0]  A1,
  input  logic [IN_DATA_WIDTH-1:0]  B1,
  input  logic [1:0]                FUNC1,
  output logic                      gnt1,
  output logic [IN_DATA_WIDTH-1:0]  alu_A,
  output logic [IN_DATA_WIDTH-1:0]  alu_B,
  output logic [1:0]                alu_FUNC,
  output logic                      alu_enable,
  input  logic [OUT_DATA_WIDTH-1:0] alu_out,
  input  logic                      alu_flag,
  output logic                      rsp_valid0,
  output logic                      rsp_valid1,
  output logic [OUT_DATA_WIDTH-1:0] rsp_data,
  output logic                      rsp_err,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d, win_q, win_d, div0_q, div0_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, alu_en_q, alu_en_d;
  logic rsp_v0_q, rsp_v0_d, rsp_v1_q, rsp_v1_d, rsp_err_q, rsp_err_d, busy_q, busy_d;
  logic [IN_DATA_WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0] alu_func_q, alu_func_d;
  logic [OUT_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic sel;
  // a lone requester wins outright; the pointer only breaks ties
  assign sel = req1 & (~req0 | ptr_q);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    win_d = win_q;
    div0_d = div0_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_func_d = alu_func_q;
    alu_en_d = 1'b0;
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    rsp_v0_d = 1'b0;
    rsp_v1_d = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: if (req0 | req1) begin
        alu_a_d = sel ? A1 : A0;
        alu_b_d = sel ? B1 : B0;
        alu_func_d = sel ? FUNC1 : FUNC0;
        alu_en_d = 1'b1;
        gnt0_d = ~sel;
        gnt1_d = sel;
        win_d = sel;
        ptr_d = ~sel;
        div0_d = (alu_func_d == 2'b11) && (alu_b_d == '0);
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        rsp_data_d = alu_out;
        rsp_err_d = div0_q | ~alu_flag;
        rsp_v0_d = ~win_q;
        rsp_v1_d = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      win_q <= 1'b0;
      div0_q <= 1'b0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_func_q <= '0;
      alu_en_q <= 1'b0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      rsp_v0_q <= 1'b0;
      rsp_v1_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      div0_q <= div0_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_func_q <= alu_func_d;
      alu_en_q <= alu_en_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      rsp_v0_q <= rsp_v0_d;
      rsp_v1_q <= rsp_v1_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      busy_q <= busy_d;
    end
  end
  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign alu_A = alu_a_q;
  assign alu_B = alu_b_q;
  assign alu_FUNC = alu_func_q;
  assign alu_enable = alu_en_q;
  assign rsp_valid0 = rsp_v0_q;
  assign rsp_valid1 = rsp_v1_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed checks of grant order, latency, responses, divide-by-zero and reset
module tb_alu_req_arbiter;
  logic CLK = 1'b0, RST = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [15:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic [1:0] FUNC0 = '0, FUNC1 = '0;
  logic gnt0, gnt1, alu_enable, rsp_valid0, rsp_valid1, rsp_err, busy;
  logic [15:0] alu_A, alu_B;
  logic [1:0] alu_FUNC;
  logic [31:0] alu_out = '0, rsp_data, res;
  logic alu_flag = 1'b0;
  int vectors = 0, miscompares = 0;
  alu_req_arbiter dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .A0(A0), .B0(B0), .FUNC0(FUNC0), .gnt0(gnt0),
    .req1(req1), .A1(A1), .B1(B1), .FUNC1(FUNC1), .gnt1(gnt1),
    .alu_A(alu_A), .alu_B(alu_B), .alu_FUNC(alu_FUNC), .alu_enable(alu_enable),
    .alu_out(alu_out), .alu_flag(alu_flag),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );
  always #5 CLK = ~CLK;
  // arithmetic unit: registered signed result, returns 0 on divide by zero without flagging it
  always_comb begin
    res = '0;
    case (alu_FUNC)
      2'b00: res = 32'($signed(alu_A) + $signed(alu_B));
      2'b01: res = 32'($signed(alu_A) - $signed(alu_B));
      2'b10: res = 32'($signed(alu_A) * $signed(alu_B));
      default: res = (alu_B == '0) ? '0 : 32'($signed(alu_A) / $signed(alu_B));
    endcase
  end
  always_ff @(posedge CLK) begin
    alu_flag <= alu_enable;
    if (alu_enable) alu_out <= res;
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic lone1(input logic [15:0] a, input logic [15:0] b, input logic [1:0] f);
    A1 = a; B1 = b; FUNC1 = f; req1 = 1'b1;
    tick();
    chk("lone1_gnt1", 32'(gnt1), 1);
    req1 = 1'b0;
    tick(2);
    chk("lone1_rsp1", 32'(rsp_valid1), 1);
  endtask
  initial begin
    tick(2);
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_data", rsp_data, 0);
    RST = 1'b1;
    tick();
    // single add
    A0 = 16'd5; B0 = 16'd7; FUNC0 = 2'b00; req0 = 1'b1;
    tick();
    chk("add_c1_gnt0", 32'(gnt0), 1);
    chk("add_c1_en", 32'(alu_enable), 1);
    chk("add_c1_busy", 32'(busy), 1);
    chk("add_c1_aluA", 32'(alu_A), 5);
    req0 = 1'b0;
    tick();
    chk("add_c2_gnt0", 32'(gnt0), 0);
    chk("add_c2_en", 32'(alu_enable), 0);
    chk("add_c2_busy", 32'(busy), 1);
    chk("add_c2_rsp0", 32'(rsp_valid0), 0);
    tick();
    chk("add_c3_rsp0", 32'(rsp_valid0), 1);
    chk("add_c3_rsp1", 32'(rsp_valid1), 0);
    chk("add_c3_data", rsp_data, 32'd12);
    chk("add_c3_err", 32'(rsp_err), 0);
    chk("add_c3_busy", 32'(busy), 0);
    tick();
    chk("add_c4_rsp0", 32'(rsp_valid0), 0);
    chk("add_c4_hold", rsp_data, 32'd12);
    // contention from a fresh reset so the pointer starts at requester 0
    RST = 1'b0;
    tick();
    RST = 1'b1;
    A0 = 16'd3; B0 = 16'd5; FUNC0 = 2'b01;
    A1 = 16'hFFFD; B1 = 16'd4; FUNC1 = 2'b10;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("rr_c1_gnt0", 32'(gnt0), 1);
    chk("rr_c1_gnt1", 32'(gnt1), 0);
    tick(2);
    chk("rr_c3_rsp0", 32'(rsp_valid0), 1);
    chk("rr_c3_rsp1", 32'(rsp_valid1), 0);
    chk("rr_c3_data", rsp_data, 32'hFFFFFFFE);
    tick();
    chk("rr_c4_gnt1", 32'(gnt1), 1);
    chk("rr_c4_gnt0", 32'(gnt0), 0);
    tick(2);
    chk("rr_c6_rsp1", 32'(rsp_valid1), 1);
    chk("rr_c6_rsp0", 32'(rsp_valid0), 0);
    chk("rr_c6_data", rsp_data, 32'hFFFFFFF4);
    tick();
    chk("rr_c7_gnt0", 32'(gnt0), 1);
    chk("rr_c7_gnt1", 32'(gnt1), 0);
    req0 = 1'b0; req1 = 1'b0;
    tick(3);
    // divide and divide-by-zero
    lone1(16'hFFF9, 16'd2, 2'b11);
    chk("div_data", rsp_data, 32'hFFFFFFFD);
    chk("div_err", 32'(rsp_err), 0);
    tick();
    lone1(16'hFFF9, 16'd0, 2'b11);
    chk("div0_data", rsp_data, 0);
    chk("div0_err", 32'(rsp_err), 1);
    tick();
    // pointer after repeated lone requester-1 use
    for (int i = 0; i < 3; i++) begin
      lone1(16'(i), 16'd1, 2'b00);
      tick();
    end
    A0 = 16'd1; B0 = 16'd1; FUNC0 = 2'b00;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("ptr_gnt0", 32'(gnt0), 1);
    chk("ptr_gnt1", 32'(gnt1), 0);
    req0 = 1'b0; req1 = 1'b0;
    tick(2);
    chk("ptr_rsp0", 32'(rsp_valid0), 1);
    chk("ptr_data", rsp_data, 32'd2);
    tick();
    // reset during WAIT abandons the op
    A0 = 16'd9; B0 = 16'd9; FUNC0 = 2'b10; req0 = 1'b1;
    tick();
    chk("mid_gnt0", 32'(gnt0), 1);
    req0 = 1'b0;
    tick();
    chk("mid_busy_wait", 32'(busy), 1);
    RST = 1'b0;
    tick();
    chk("mid_rst_gnt", 32'({gnt0, gnt1}), 0);
    chk("mid_rst_rsp", 32'({rsp_valid0, rsp_valid1}), 0);
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_err", 32'(rsp_err), 0);
    chk("mid_rst_alu", {alu_A, alu_B}, 0);
    chk("mid_rst_func_en", 32'({alu_FUNC, alu_enable}), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_rsp", 32'({rsp_valid0, rsp_valid1}), 0);
    end
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("post_rst_gnt0", 32'(gnt0), 1);
    chk("post_rst_gnt1", 32'(gnt1), 0);
    req0 = 1'b0; req1 = 1'b0;
    tick(3);
    // withdrawn request raised only during ISSUE of another op
    A1 = 16'd4; B1 = 16'd2; FUNC1 = 2'b01; req1 = 1'b1;
    tick();
    chk("wd_gnt1", 32'(gnt1), 1);
    req1 = 1'b0; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    chk("wd_rsp1", 32'(rsp_valid1), 1);
    chk("wd_data", rsp_data, 32'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wd_no_gnt0", 32'(gnt0), 0);
      chk("wd_no_rsp0", 32'(rsp_valid0), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
